// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state encoding, width derivation and saturation helpers for the row accumulator
package pe_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Eight row terms plus a bias always fit in 2*BITWIDTH+4 bits.
    function automatic int acc_width(input int bitwidth);
        return 2 * bitwidth + 4;
    endfunction

    function automatic int sat_max(input int bitwidth);
        return (1 << (bitwidth - 1)) - 1;
    endfunction

    function automatic int sat_min(input int bitwidth);
        return -(1 << (bitwidth - 1));
    endfunction

endpackage

// File: rtl/row_accumulator_if.sv
// rtl/row_accumulator_if.sv - input/output handshake bundle of the row accumulator
interface row_accumulator_if #(
    parameter int BITWIDTH = 8
);
    logic                         in_valid;
    logic signed [2*BITWIDTH-1:0] din;
    logic signed [2*BITWIDTH-1:0] bias;
    logic                         flush;
    logic                         in_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [BITWIDTH-1:0]   dout;
    logic                         busy;

    modport master (
        output in_valid, din, bias, flush, out_ready,
        input  in_ready, out_valid, dout, busy
    );

    modport slave (
        input  in_valid, din, bias, flush, out_ready,
        output in_ready, out_valid, dout, busy
    );
endinterface

// File: rtl/row_accumulator_shift_saturate.sv
// rtl/row_accumulator_shift_saturate.sv - floor shift and clamp to BITWIDTH, optional ReLU via ROW_ACCUMULATOR_RELU_EN
module shift_saturate #(
    parameter int ACC_W    = 20,
    parameter int BITWIDTH = 8,
    parameter int SHIFT    = 4
) (
    input  logic signed [ACC_W-1:0]    sum_i,
    output logic signed [BITWIDTH-1:0] sat_o
);
    import pe_pkg::*;

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(BITWIDTH));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(BITWIDTH));

    logic signed [ACC_W-1:0]    shifted;
    logic signed [BITWIDTH-1:0] clipped;

    // Arithmetic shift rounds toward minus infinity.
    assign shifted = sum_i >>> SHIFT;

    // Clamp the shifted sum into the signed output range.
    always_comb begin
        clipped = shifted[BITWIDTH-1:0];
        if (shifted > MAX_V) begin
            clipped = MAX_V[BITWIDTH-1:0];
        end else if (shifted < MIN_V) begin
            clipped = MIN_V[BITWIDTH-1:0];
        end
    end

`ifdef ROW_ACCUMULATOR_RELU_EN
    assign sat_o = clipped[BITWIDTH-1] ? '0 : clipped;
`else
    assign sat_o = clipped;
`endif

endmodule

// File: rtl/row_accumulator.sv
// rtl/row_accumulator.sv - sums KROWS row-filter results plus bias, rescales, saturates (ReLU via ROW_ACCUMULATOR_RELU_EN)
module row_accumulator #(
    parameter int BITWIDTH = 8,
    parameter int KROWS    = 3,
    parameter int SHIFT    = 4
) (
    input  logic               clk,
    input  logic               rst,
    row_accumulator_if.slave   bus
);
    import pe_pkg::*;

    localparam int ACC_W = acc_width(BITWIDTH);
    localparam int CNT_W = clog2(KROWS + 1);
    localparam int EXT_W = ACC_W - 2 * BITWIDTH;

    logic [1:0]                 state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [BITWIDTH-1:0] dout_q, dout_d;

    logic                       in_ready;
    logic                       accept;
    logic                       pop;
    logic                       last;
    logic signed [ACC_W-1:0]    din_x;
    logic signed [ACC_W-1:0]    bias_x;
    logic signed [ACC_W-1:0]    total;
    logic signed [BITWIDTH-1:0] sat;

    assign din_x  = {{EXT_W{bus.din[2*BITWIDTH-1]}}, bus.din};
    assign bias_x = {{EXT_W{bus.bias[2*BITWIDTH-1]}}, bus.bias};
    assign total  = acc_q + din_x + bias_x;

    // A flush or an unread result blocks new samples; reset holds in_ready low.
    assign in_ready = rst && !bus.flush && !(state_q == ST_HOLD && !bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign pop      = (state_q == ST_HOLD) && bus.out_ready;
    assign last     = accept && (cnt_q == CNT_W'(KROWS - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.dout      = dout_q;
    assign bus.busy      = (cnt_q != '0);

    shift_saturate #(
        .ACC_W    (ACC_W),
        .BITWIDTH (BITWIDTH),
        .SHIFT    (SHIFT)
    ) u_shift_saturate (
        .sum_i (total),
        .sat_o (sat)
    );

    // Next-state: pop the held result, then flush or fold in the accepted sample.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        if (pop) begin
            state_d = ST_IDLE;
        end
        if (bus.flush) begin
            acc_d = '0;
            cnt_d = '0;
            if (state_q == ST_ACCUM) begin
                state_d = ST_IDLE;
            end
        end else if (accept) begin
            if (last) begin
                dout_d  = sat;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_HOLD;
            end else if (cnt_q == '0) begin
                acc_d   = din_x;
                cnt_d   = CNT_W'(1);
                state_d = ST_ACCUM;
            end else begin
                acc_d = acc_q + din_x;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_row_accumulator.sv
// tb/tb_row_accumulator.sv - randomized scoreboard bench for row_accumulator
module tb_row_accumulator;

    localparam int BW = 8;
    localparam int KR = 3;
    localparam int SH = 4;
    localparam int OUT_MAX = (1 << (BW - 1)) - 1;
    localparam int OUT_MIN = -(1 << (BW - 1));
`ifdef ROW_ACCUMULATOR_RELU_EN
    localparam int NEG_SAT_EXP = 0;
`else
    localparam int NEG_SAT_EXP = -128;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    row_accumulator_if #(.BITWIDTH(BW)) bus ();

    row_accumulator #(
        .BITWIDTH (BW),
        .KROWS    (KR),
        .SHIFT    (SH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    // Reference model: the samples of the current group and whether a result awaits pickup.
    int grp_sum  = 0;
    int grp_cnt  = 0;
    bit pending  = 1'b0;
    int exp_dout = 0;

    function automatic int ref_result(input int total);
        int q;
        q = total >>> SH;
        if (q > OUT_MAX) q = OUT_MAX;
        if (q < OUT_MIN) q = OUT_MIN;
`ifdef ROW_ACCUMULATOR_RELU_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model is checked and advanced at the falling edge.
    task automatic step(input bit v, input int d, input int b, input bit f, input bit ordy, input bit r);
        bit exp_rdy;
        bit acc;
        bus.in_valid  = v;
        bus.din       = 16'(d);
        bus.bias      = 16'(b);
        bus.flush     = f;
        bus.out_ready = ordy;
        rst           = r;
        @(negedge clk);
        exp_rdy = r && !f && !(pending && !ordy);
        check("in_ready", int'(bus.in_ready), int'(exp_rdy));
        check("out_valid", int'(bus.out_valid), int'(pending));
        check("busy", int'(bus.busy), int'(grp_cnt != 0));
        check("dout", int'($signed(bus.dout)), exp_dout);
        acc = v && exp_rdy;
        if (!r) begin
            grp_sum  = 0;
            grp_cnt  = 0;
            pending  = 1'b0;
            exp_dout = 0;
            exp_q.delete();
        end else begin
            if (pending && ordy) pending = 1'b0;
            if (f) begin
                grp_sum = 0;
                grp_cnt = 0;
            end else if (acc) begin
                grp_sum += d;
                grp_cnt++;
                if (grp_cnt == KR) begin
                    exp_dout = ref_result(grp_sum + b);
                    exp_q.push_back(exp_dout);
                    pending = 1'b1;
                    grp_sum = 0;
                    grp_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handed-off result must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: got unexpected result %0d, expected none", $signed(bus.dout));
                end else begin
                    check("scoreboard", int'($signed(bus.dout)), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.bias      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1, 0);

        // Basic sum and latency
        step(1, 100, 0, 0, 1, 1);
        step(1, 200, 0, 0, 1, 1);
        step(1, 300, 16, 0, 0, 1);
        check("basic_dout", int'($signed(bus.dout)), 38);
        check("basic_valid", int'(bus.out_valid), 1);

        // Backpressure, then pop together with a new first sample
        repeat (5) step(1, 77, 0, 0, 0, 1);
        check("held_dout", int'($signed(bus.dout)), 38);
        step(1, 50, 0, 0, 1, 1);
        step(1, 50, 0, 0, 1, 1);
        step(1, 50, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);

        // Saturation both ways
        repeat (3) step(1, 1000, 0, 0, 1, 1);
        check("pos_sat", int'($signed(bus.dout)), 127);
        repeat (3) step(1, -1000, 0, 0, 1, 1);
        check("neg_sat", int'($signed(bus.dout)), NEG_SAT_EXP);

        // Flush after two samples, and flush dropping a presented sample
        step(1, 100, 0, 0, 1, 1);
        step(1, 200, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1, 1);
        repeat (3) step(1, 5, 0, 0, 1, 1);
        check("flush_dout", int'($signed(bus.dout)), 0);
        step(1, 7, 0, 0, 1, 1);
        step(1, 999, 0, 1, 1, 1);
        repeat (3) step(1, 16, 0, 0, 1, 1);
        check("flush_drop_dout", int'($signed(bus.dout)), 3);

        // Continuous stream of nine samples
        repeat (9) step(1, 16, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);

        // Reset in ACCUM and in HOLD
        step(1, 100, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        check("rst_accum_busy", int'(bus.busy), 0);
        check("rst_accum_dout", int'($signed(bus.dout)), 0);
        step(1, 100, 0, 0, 1, 1);
        step(1, 200, 0, 0, 1, 1);
        step(1, 300, 16, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        check("rst_hold_valid", int'(bus.out_valid), 0);
        check("rst_hold_dout", int'($signed(bus.dout)), 0);
        step(1, 100, 0, 0, 1, 1);
        step(1, 200, 0, 0, 1, 1);
        step(1, 300, 16, 0, 1, 1);
        check("post_rst_dout", int'($signed(bus.dout)), 38);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic signed [15:0] w;
            int d;
            int b;
            w = 16'($urandom);
            d = ($urandom_range(0, 1) == 1) ? int'(w) : int'($urandom_range(0, 1200)) - 600;
            w = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? int'(w) : int'($urandom_range(0, 64)) - 32;
            step($urandom_range(0, 3) != 0, d, b, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
        end

        // Drain
        repeat (4) step(0, 0, 0, 0, 1, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
